// File: rtl/line_clear_ctrl.sv
// Line-clear pass for a falling-block game board: scans rows bottom-up, compacts
// non-full rows downward and zero-fills the vacated top rows.
module line_clear_ctrl #(
  parameter int unsigned N_COLS = 10,
  parameter int unsigned N_ROWS = 20,
  parameter int unsigned CW     = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [4:0]             o_lines,
  output logic [4:0]             o_rd_row,
  input  logic [N_COLS*CW-1:0]   i_rd_data,
  output logic                   o_wr_en,
  output logic [4:0]             o_wr_row,
  output logic [N_COLS*CW-1:0]   o_wr_data
);

  localparam logic [4:0] LastRow = 5'(N_ROWS - 1);
  localparam logic [4:0] MaxLines = 5'(N_ROWS);

  typedef enum logic [2:0] {StIdle, StRead, StEval, StFill, StDone} state_e;

  state_e     state_q, state_d;
  logic [4:0] src_q, src_d;
  logic [4:0] dst_q, dst_d;
  logic [4:0] lines_q, lines_d;
  logic [4:0] lines_out_q;
  logic       busy_q, done_q;
  logic       row_full;

  always_comb begin
    row_full = 1'b1;
    for (int unsigned c = 0; c < N_COLS; c++) begin
      if (i_rd_data[c*CW +: CW] == '0) row_full = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    lines_d   = lines_q;
    o_wr_en   = 1'b0;
    o_wr_data = '0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          src_d   = LastRow;
          dst_d   = LastRow;
          lines_d = '0;
          state_d = StRead;
        end
      end
      StRead: state_d = StEval;
      StEval: begin
        if (row_full) begin
          if (lines_q < MaxLines) lines_d = lines_q + 5'd1;
        end else begin
          o_wr_en   = 1'b1;
          o_wr_data = i_rd_data;
          // After the last non-full write dst equals lines-1, which FILL relies on.
          if (dst_q != '0) dst_d = dst_q - 5'd1;
        end
        if (src_q != '0) begin
          src_d   = src_q - 5'd1;
          state_d = StRead;
        end else begin
          state_d = (lines_d != '0) ? StFill : StDone;
        end
      end
      StFill: begin
        o_wr_en = 1'b1;
        if (dst_q == '0) state_d = StDone;
        else             dst_d   = dst_q - 5'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      lines_q     <= '0;
      lines_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      lines_q <= lines_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
      if (state_d == StDone && state_q != StDone) lines_out_q <= lines_d;
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_lines  = lines_out_q;
  assign o_rd_row = src_q;
  assign o_wr_row = dst_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: board memory model plus a row-compaction reference.
module tb_line_clear_ctrl;

  localparam int NC = 10;
  localparam int NR = 20;
  localparam int CW = 3;
  localparam int W  = NC * CW;

  logic         clk = 1'b0;
  logic         i_rst, i_start;
  logic         o_busy, o_done, o_wr_en;
  logic [4:0]   o_lines, o_rd_row, o_wr_row;
  logic [W-1:0] rd_data, o_wr_data;
  logic [W-1:0] board [NR];

  int n_cmp = 0;
  int n_bad = 0;

  line_clear_ctrl #(.N_COLS(NC), .N_ROWS(NR), .CW(CW)) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_lines  (o_lines),
    .o_rd_row (o_rd_row),
    .i_rd_data(rd_data),
    .o_wr_en  (o_wr_en),
    .o_wr_row (o_wr_row),
    .o_wr_data(o_wr_data)
  );

  always #5 clk = ~clk;

  // Board storage: synchronous read, one-cycle latency.
  always @(posedge clk) begin
    rd_data <= (o_rd_row < NR) ? board[o_rd_row] : '0;
    if (o_wr_en && o_wr_row < NR) board[o_wr_row] <= o_wr_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_full(input logic [W-1:0] row);
    for (int c = 0; c < NC; c++) if (row[c*CW +: CW] == '0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r = '0;
    int unsigned  m = $urandom_range(0, 2);
    for (int c = 0; c < NC; c++) begin
      if (m == 1)      r[c*CW +: CW] = CW'($urandom_range(1, 7));
      else if (m == 2) r[c*CW +: CW] = CW'($urandom_range(0, 7));
    end
    return r;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < NR; r++) board[r] = rand_row();
  endtask

  // One full pass; the expected board keeps surviving rows in order, packed at the bottom.
  task automatic run_pass(input bit repulse);
    logic [W-1:0] exp_b [NR];
    bit           fl [NR];
    int           nl = 0;
    int           k = NR - 1;
    int           writes = 0;
    int           done_c;
    for (int r = NR - 1; r >= 0; r--) begin
      fl[r] = is_full(board[r]);
      if (fl[r]) nl++;
      else begin
        exp_b[k] = board[r];
        k--;
      end
    end
    for (int r = k; r >= 0; r--) exp_b[r] = '0;
    done_c = 2 * NR + 1 + nl;

    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= done_c; c++) begin
      i_start = repulse && (c == 5 || c == done_c);
      chk("busy", 32'(o_busy), 32'd1);
      chk("done", 32'(o_done), 32'(c == done_c));
      if (c <= 2 * NR && (c % 2) == 1) begin
        chk("rd_row", 32'(o_rd_row), 32'(NR - 1 - (c - 1) / 2));
        chk("wr_en_read", 32'(o_wr_en), 32'd0);
      end else if (c <= 2 * NR) begin
        chk("wr_en_eval", 32'(o_wr_en), 32'(!fl[NR - c / 2]));
      end else if (c < done_c) begin
        chk("wr_en_fill", 32'(o_wr_en), 32'd1);
        chk("wr_row_fill", 32'(o_wr_row), 32'(nl - 1 - (c - 2 * NR - 1)));
        chk("wr_data_fill", 32'(o_wr_data), 32'd0);
      end else begin
        chk("wr_en_done", 32'(o_wr_en), 32'd0);
        chk("lines", 32'(o_lines), 32'(nl));
      end
      if (o_wr_en) writes++;
      tick();
    end
    i_start = 1'b0;
    chk("writes", 32'(writes), 32'(NR));
    for (int i = 0; i < 3; i++) begin
      chk("busy_after", 32'(o_busy), 32'd0);
      chk("done_after", 32'(o_done), 32'd0);
      chk("wr_en_idle", 32'(o_wr_en), 32'd0);
      tick();
    end
    chk("lines_hold", 32'(o_lines), 32'(nl));
    for (int r = 0; r < NR; r++) chk($sformatf("board[%0d]", r), 32'(board[r]), 32'(exp_b[r]));
  endtask

  initial begin
    logic [W-1:0] p_row, q_row, full3;
    full3 = '0;
    for (int c = 0; c < NC; c++) full3[c*CW +: CW] = 3'd3;
    p_row = W'(1);
    q_row = W'(2) << CW;
    for (int r = 0; r < NR; r++) board[r] = '0;
    i_start = 1'b0;
    i_rst   = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_lines", 32'(o_lines), 32'd0);
    chk("rst_wr_en", 32'(o_wr_en), 32'd0);
    chk("rst_rd_row", 32'(o_rd_row), 32'd0);
    chk("rst_wr_row", 32'(o_wr_row), 32'd0);
    chk("rst_wr_data", 32'(o_wr_data), 32'd0);
    i_rst = 1'b0;
    tick();

    // Empty board.
    run_pass(1'b0);

    // Bottom row full, piece row above it.
    for (int r = 0; r < NR; r++) board[r] = '0;
    board[19] = full3;
    board[18] = p_row;
    run_pass(1'b0);
    chk("p_dropped", 32'(board[19]), 32'(p_row));

    // Two full rows interleaved with survivors.
    for (int r = 0; r < NR; r++) board[r] = '0;
    board[19] = full3;
    board[18] = p_row;
    board[17] = full3;
    board[16] = q_row;
    run_pass(1'b0);
    chk("p_final", 32'(board[19]), 32'(p_row));
    chk("q_final", 32'(board[18]), 32'(q_row));

    // Every row full.
    for (int r = 0; r < NR; r++) board[r] = full3;
    run_pass(1'b0);

    // Reset in the EVAL cycle for src=10 aborts the pass.
    fill_random();
    board[5] = full3;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_wr_en", 32'(o_wr_en), 32'd0);
    chk("abort_lines", 32'(o_lines), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    run_pass(1'b0);

    // Reset wins over a simultaneous start.
    i_rst   = 1'b1;
    i_start = 1'b1;
    tick();
    i_rst   = 1'b0;
    i_start = 1'b0;
    tick();
    chk("rst_prio_busy", 32'(o_busy), 32'd0);

    // Start re-pulsed mid-pass and during DONE is ignored.
    fill_random();
    run_pass(1'b1);

    for (int t = 0; t < 20; t++) begin
      fill_random();
      run_pass(t[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
